// File: rtl/jtcop_pkg.sv
// Shared jtcop definitions: object RAM geometry and the object DMA state set.
package jtcop_pkg;

   localparam int OBJ_WORDS = 1024;
   localparam int OBJ_AW    = 10;

   localparam logic [OBJ_AW-1:0] OBJ_LAST = OBJ_AW'(OBJ_WORDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COPY   = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_WAITBG = 2'd3
   } dma_st_e;

endpackage

// File: rtl/jtcop_objram.sv
// CPU-side object RAM: single port, byte enables, registered read data.
module jtcop_objram
   import jtcop_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [OBJ_AW-1:0] addr,
   input  logic              we,
   input  logic [1:0]        be,
   input  logic [15:0]       din,
   output logic [15:0]       dout
);

   logic [15:0] mem [OBJ_WORDS];

   // Contents survive reset; only the read register is cleared.
   always_ff @(posedge clk) begin
      if (we && be[0]) mem[addr][7:0]  <= din[7:0];
      if (we && be[1]) mem[addr][15:8] <= din[15:8];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) dout <= '0;
      else     dout <= mem[addr];
   end

endmodule

// File: rtl/jtcop_obj_dma.sv
// Object RAM to renderer buffer copier, started at VBLANK.
// JTCOP_DMA_BUSREQ_EN: hold the CPU off with br/bg instead of cycle stealing.
module jtcop_obj_dma
   import jtcop_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        obj_copy,
   input  logic        obj_cs,
   input  logic        cpu_rnw,
   input  logic [10:1] cpu_addr,
   input  logic [15:0] cpu_dout,
   input  logic [1:0]  cpu_dsn,
   output logic [15:0] cpu_din,
   output logic        buf_we,
   output logic [9:0]  buf_addr,
   output logic [15:0] buf_din,
   output logic        busy,
`ifdef JTCOP_DMA_BUSREQ_EN
   output logic        br,
   input  logic        bg,
`endif
   output logic        done
);

   dma_st_e st, st_nx;

   logic [OBJ_AW-1:0] rd_cnt;
   logic [OBJ_AW-1:0] rd_addr;
   logic              rd_vld;
   logic              rd_go;
   logic [OBJ_AW-1:0] ram_addr;
   logic              ram_we;
   logic [15:0]       ram_q;

`ifdef JTCOP_DMA_BUSREQ_EN
   assign rd_go = (st == ST_COPY);
`else
   assign rd_go = (st == ST_COPY) && !obj_cs;
`endif

   // The DMA owns the port only on cycles the CPU leaves free.
   assign ram_addr = rd_go ? rd_cnt : cpu_addr;
   assign ram_we   = obj_cs && !cpu_rnw && !rd_go;

   jtcop_objram u_ram (
      .clk  (clk),
      .rst  (rst),
      .addr (ram_addr),
      .we   (ram_we),
      .be   (~cpu_dsn),
      .din  (cpu_dout),
      .dout (ram_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) st <= ST_IDLE;
      else     st <= st_nx;
   end

   always_comb begin
      st_nx = st;
      unique case (st)
         ST_IDLE: begin
`ifdef JTCOP_DMA_BUSREQ_EN
            if (obj_copy) st_nx = ST_WAITBG;
`else
            if (obj_copy) st_nx = ST_COPY;
`endif
         end
         ST_WAITBG: begin
`ifdef JTCOP_DMA_BUSREQ_EN
            if (bg) st_nx = ST_COPY;
`else
            st_nx = ST_IDLE;
`endif
         end
         ST_COPY: begin
            if (rd_go && rd_cnt == OBJ_LAST) st_nx = ST_FLUSH;
         end
         ST_FLUSH: st_nx = ST_IDLE;
         default:  st_nx = ST_IDLE;
      endcase
   end

   // Read counter and the one-deep write pipeline behind it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_cnt  <= '0;
         rd_addr <= '0;
         rd_vld  <= 1'b0;
      end else begin
         rd_vld <= rd_go;
         if (rd_go) begin
            rd_addr <= rd_cnt;
            rd_cnt  <= rd_cnt + 10'd1;
         end else if (st == ST_IDLE) begin
            rd_cnt <= '0;
         end
      end
   end

   assign cpu_din  = ram_q;
   assign buf_we   = rd_vld;
   assign buf_addr = rd_addr;
   assign buf_din  = ram_q;
   assign busy     = (st != ST_IDLE);
   assign done     = (st == ST_FLUSH);

`ifdef JTCOP_DMA_BUSREQ_EN
   assign br = (st == ST_WAITBG) || (st == ST_COPY);
`endif

endmodule

// File: tb/tb_jtcop_obj_dma.sv
// Bench for jtcop_obj_dma: RAM/buffer model, per-write monitor, directed copies.
module tb_jtcop_obj_dma;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        obj_copy = 1'b0;
   logic        obj_cs = 1'b0;
   logic        cpu_rnw = 1'b1;
   logic [10:1] cpu_addr = '0;
   logic [15:0] cpu_dout = '0;
   logic [1:0]  cpu_dsn = 2'b11;
   logic [15:0] cpu_din;
   logic        buf_we;
   logic [9:0]  buf_addr;
   logic [15:0] buf_din;
   logic        busy;
   logic        done;
`ifdef JTCOP_DMA_BUSREQ_EN
   logic        br;
   logic        bg = 1'b0;
   localparam int EXTRA = 20;
`else
   localparam int EXTRA = 0;
`endif

   jtcop_obj_dma dut (
      .clk      (clk),
      .rst      (rst),
      .obj_copy (obj_copy),
      .obj_cs   (obj_cs),
      .cpu_rnw  (cpu_rnw),
      .cpu_addr (cpu_addr),
      .cpu_dout (cpu_dout),
      .cpu_dsn  (cpu_dsn),
      .cpu_din  (cpu_din),
      .buf_we   (buf_we),
      .buf_addr (buf_addr),
      .buf_din  (buf_din),
      .busy     (busy),
`ifdef JTCOP_DMA_BUSREQ_EN
      .br       (br),
      .bg       (bg),
`endif
      .done     (done)
   );

   always #5 clk = ~clk;

   int chk_cnt = 0;
   int pass_cnt = 0;

   logic [15:0] model_ram [1024];
   bit          wr_seen [1024];
   int          exp_next = 0;
   int          nwr = 0;
   int          ndone = 0;
   int          cur_c = 0;
   int          first_wr = -1;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every buffer write must be the next address in order, once, with RAM data.
   always @(negedge clk) begin
      if (!rst) begin
         if (buf_we) begin
            check("wr_busy", 32'(busy), 32'd1);
            check("wr_seq", 32'(buf_addr), 32'(exp_next[9:0]));
            check("wr_once", 32'(wr_seen[buf_addr]), 32'd0);
            check("wr_data", 32'(buf_din), 32'(model_ram[buf_addr]));
            wr_seen[buf_addr] = 1'b1;
            exp_next++;
            nwr++;
            if (first_wr < 0) first_wr = cur_c;
         end
         if (done) ndone++;
      end
   end

   task automatic cpu_write(input int a, input logic [15:0] d,
                            input logic [1:0] dsn);
      obj_cs   = 1'b1;
      cpu_rnw  = 1'b0;
      cpu_addr = 10'(a);
      cpu_dout = d;
      cpu_dsn  = dsn;
      tick();
      obj_cs  = 1'b0;
      cpu_rnw = 1'b1;
      cpu_dsn = 2'b11;
      if (!dsn[0]) model_ram[a][7:0]  = d[7:0];
      if (!dsn[1]) model_ram[a][15:8] = d[15:8];
   endtask

   task automatic cpu_read(input int a, input string name,
                           input logic [15:0] exp);
      obj_cs   = 1'b1;
      cpu_rnw  = 1'b1;
      cpu_addr = 10'(a);
      tick();
      obj_cs = 1'b0;
      check(name, 32'(cpu_din), 32'(exp));
   endtask

   // Runs one copy; rst_at > 0 aborts it with a reset at that cycle.
   task automatic run_copy(input int steal_at, input int steal_n,
                           input int dup_at, input int rst_at,
                           input int exp_done);
      int c;
      int prev_rd;
      int d0;
      bit got;
      for (int i = 0; i < 1024; i++) wr_seen[i] = 1'b0;
      exp_next = 0;
      nwr      = 0;
      first_wr = -1;
      d0       = ndone;
      got      = 1'b0;
      prev_rd  = -1;
      obj_copy = 1'b1;
      tick();
      obj_copy = 1'b0;
      c = 1;
      while (c <= 2000 && !got) begin
         cur_c   = c;
         obj_cs  = 1'b0;
         cpu_rnw = 1'b1;
         if (c >= steal_at && c < steal_at + steal_n) begin
            obj_cs   = 1'b1;
            cpu_addr = 10'(100 + c - steal_at);
         end
         obj_copy = (c == dup_at);
`ifdef JTCOP_DMA_BUSREQ_EN
         bg = (c >= EXTRA) && (c < 600);
`endif
         if (c == rst_at) begin
            rst = 1'b1;
            #1;
            check("rst_we", 32'(buf_we), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_addr", 32'(buf_addr), 32'd0);
            tick();
            tick();
            rst      = 1'b0;
            obj_cs   = 1'b0;
            obj_copy = 1'b0;
`ifdef JTCOP_DMA_BUSREQ_EN
            bg = 1'b0;
`endif
            tick();
            check("rst_no_done", 32'(ndone - d0), 32'd0);
            check("rst_partial", 32'(nwr), 32'(rst_at - 2 - EXTRA));
            check("rst_idle", 32'(busy), 32'd0);
            return;
         end
`ifndef JTCOP_DMA_BUSREQ_EN
         if (prev_rd >= 0)
            check("cpu_rd", 32'(cpu_din), 32'(model_ram[prev_rd]));
         prev_rd = obj_cs ? 100 + c - steal_at : -1;
`else
         check("br", 32'(br), 32'(c < exp_done));
`endif
         check("busy", 32'(busy), 32'(c <= exp_done));
         if (done) begin
            got = 1'b1;
            check("done_cyc", 32'(c), 32'(exp_done));
         end
         tick();
         c++;
      end
      obj_cs   = 1'b0;
      obj_copy = 1'b0;
      check("done_seen", 32'(got), 32'd1);
      check("busy_after", 32'(busy), 32'd0);
      check("nwr", 32'(nwr), 32'd1024);
      check("ndone", 32'(ndone - d0), 32'd1);
`ifdef JTCOP_DMA_BUSREQ_EN
      check("first_wr", 32'(first_wr), 32'(EXTRA + 2));
      check("br_after", 32'(br), 32'd0);
      bg = 1'b0;
`endif
   endtask

   initial begin
      #12;
      check("reset_we", 32'(buf_we), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_addr", 32'(buf_addr), 32'd0);
      check("reset_din", 32'(buf_din), 32'd0);
`ifdef JTCOP_DMA_BUSREQ_EN
      check("reset_br", 32'(br), 32'd0);
`endif
      tick();
      rst = 1'b0;
      tick();

      for (int n = 0; n < 1024; n++) cpu_write(n, 16'(n) ^ 16'hA5A5, 2'b00);
      cpu_read(3, "rd_pin3", 16'hA5A6);
      cpu_read(1023, "rd_pin3ff", 16'hA65A);
      cpu_read(0, "rd_pin0", 16'hA5A5);

      cpu_write(5, 16'hFFFF, 2'b00);
      cpu_write(5, 16'h1234, 2'b10);
      cpu_read(5, "rd_bytelane", 16'hFF34);
      check("model_bytelane", 32'(model_ram[5]), 32'h0000FF34);
      tick();

      run_copy(0, 0, -1, -1, 1025 + EXTRA);
      tick();
`ifdef JTCOP_DMA_BUSREQ_EN
      run_copy(200, 10, -1, -1, 1025 + EXTRA);
`else
      run_copy(200, 10, -1, -1, 1035);
`endif
      tick();
      run_copy(0, 0, 500, -1, 1025 + EXTRA);
      tick();
      run_copy(0, 0, -1, 300, 1025 + EXTRA);
      tick();
      run_copy(0, 0, -1, -1, 1025 + EXTRA);
      tick();
      cpu_read(5, "rd_after", 16'hFF34);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/jtcop_obj_dma.md
JTCOP_OBJ_DMA -- requirements
Module: jtcop_obj_dma

Interface
REQ-001 SHALL have port clk, input, 1: system clock, all logic on rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port obj_copy, input, 1: one-cycle copy request pulse from the address decoder at the VBLANK falling edge.
REQ-004 SHALL have port obj_cs, input, 1: CPU object RAM select from the decoder.
REQ-005 SHALL have port cpu_rnw, input, 1: CPU read (1) or write (0).
REQ-006 SHALL have ports cpu_addr[10:1], cpu_dout[15:0] and cpu_dsn[1:0], inputs: CPU word address, write data and active-low byte strobes.
REQ-007 SHALL have port cpu_din, output, 16: object RAM read data to the CPU.
REQ-008 SHALL have ports buf_we (output, 1), buf_addr (output, 10) and buf_din (output, 16): write port of the renderer object buffer.
REQ-009 SHALL have port busy, output, 1: copy in progress.
REQ-010 SHALL have port done, output, 1: one-cycle pulse when the last word is written.
REQ-011 SHALL have, only with JTCOP_DMA_BUSREQ_EN defined, ports br (output, 1: bus request) and bg (input, 1: bus grant).

Function
REQ-012 SHALL hold the CPU-side object RAM: 1024x16, byte-writable via cpu_dsn, 1-cycle read latency.
REQ-013 SHALL write CPU data on obj_cs & !cpu_rnw, and SHALL return cpu_din one cycle after address is presented.
REQ-014 SHALL implement FSM IDLE -> COPY -> FLUSH -> IDLE (plus WAITBG under the macro).
REQ-015 SHALL leave IDLE on obj_copy; obj_copy while busy SHALL be ignored (no queueing).
REQ-016 COPY SHALL issue one RAM read per free cycle using a 10-bit read counter starting at 0.
REQ-017 SHALL define a free cycle as one with obj_cs low; a CPU access SHALL take the RAM port and freeze the read counter.
REQ-018 SHALL pipeline writes: buf_we=1, buf_addr=read address of previous free cycle, buf_din=its RAM data, exactly 1 cycle after each DMA read.
REQ-019 SHALL move COPY -> FLUSH after issuing read 1023; FLUSH SHALL emit the final write and pulse done in the same cycle.
REQ-020 SHALL take 1025 cycles from obj_copy to done with no CPU contention; each stolen cycle SHALL add exactly one cycle.
REQ-021 SHALL keep busy high from the cycle after obj_copy through the done cycle inclusive.
REQ-022 SHALL never assert buf_we outside COPY/FLUSH, and SHALL never write a buffer address twice per copy.

Reset
REQ-023 SHALL on rst: state IDLE, counters 0, buf_we=0, busy=0, done=0, br=0, buf_addr=0, buf_din=0.
REQ-024 SHALL on rst mid-copy abort immediately with no further buffer writes and no done pulse; RAM contents are undefined-preserved (not cleared).

Configuration
REQ-025 SHALL, with JTCOP_DMA_BUSREQ_EN defined, go IDLE -> WAITBG on obj_copy, assert br, and enter COPY only on bg=1; in COPY obj_cs SHALL be ignored (no cycle stealing).
REQ-026 SHALL drop br in the done cycle.
REQ-027 SHALL ignore bg dropping mid-copy.
REQ-028 SHALL, without JTCOP_DMA_BUSREQ_EN, use cycle stealing per REQ-017; br and bg SHALL NOT exist.

Structure
REQ-029 SHALL place OBJ_WORDS=1024 and the FSM state enum in the shared jtcop package.
REQ-030 SHALL instantiate the object RAM as one sub-module, jtcop_objram (single port, byte enables, registered read).
REQ-031 FSM, counters and write pipeline SHALL stay in jtcop_obj_dma.

Verification
REQ-032 SHALL test: fill RAM[n]=n^16'hA5A5, obj_copy, no CPU traffic -> 1024 buffer writes addr n data n^A5A5, done at cycle 1025.
REQ-033 SHALL test: obj_cs asserted 10 cycles during copy -> done at cycle 1035, buffer contents still exact, CPU reads correct.
REQ-034 SHALL test: second obj_copy at cycle 500 -> ignored, one done pulse, 1024 writes total.
REQ-035 SHALL test: rst at cycle 300 -> buf_we low next edge, busy=0, no done; new obj_copy -> full copy from addr 0.
REQ-036 SHALL test: CPU write cpu_dsn=2'b10 data 16'h1234 at addr 5 over 16'hFFFF -> RAM[5]=16'hFF34, copied to buffer.
REQ-037 SHALL test with JTCOP_DMA_BUSREQ_EN: bg delayed 20 cycles -> br high throughout, first buf_we one cycle after COPY entry, br low at done.
